mandel_iter_ctrl: RTL and testbench

//  Per-iterator pixel sequencer sitting directly upstream of the arbiter.
//  - Walks its share of the screen (interleaved columns x = ITER_ID + k*N_ITER, all rows).
//  - For each pixel: loads cr/ci into one mandelbrot core, waits for the core flag, maps N to an RGB332 colour.
//  - Presents {address, colour} to the arbiter via the select/comp_flag handshake; raises done after its last pixel.

---
 rtl/mandel_iter_ctrl.sv | 158 +++++++++++++++
 tb/tb_mandel_iter_ctrl.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandel_iter_ctrl.sv
// Pixel sequencer for one Mandelbrot iterator: walks its interleaved columns, runs one
// core per pixel, maps the iteration count to RGB332 and hands {address, colour} to the arbiter.
module mandel_iter_ctrl #(
  parameter int          ITER_ID = 0,
  parameter int          N_ITER  = 6,
  parameter int          X_RES   = 640,
  parameter int          Y_RES   = 480,
  parameter logic [26:0] X_START = 27'h7000000,
  parameter logic [26:0] Y_START = 27'h0800000,
  parameter logic [26:0] DX      = 27'd39322,
  parameter logic [26:0] DY      = 27'd34953
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [26:0] max_iterations,
  input  logic [26:0] core_N,
  input  logic [26:0] core_flag,
  input  logic        comp_flag,
  output logic        core_reset,
  output logic [26:0] cr,
  output logic [26:0] ci,
  output logic [31:0] vga_addr,
  output logic [31:0] vga_pxl_clr,
  output logic        select,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT_ACK, ADVANCE, DONE} state_t;

  localparam logic [31:0] X_FIRST    = 32'(ITER_ID);
  localparam logic [31:0] X_STEP     = 32'(N_ITER);
  localparam logic [31:0] X_LIMIT    = 32'(X_RES);
  localparam logic [31:0] Y_LAST     = 32'(Y_RES - 1);
  localparam logic [26:0] CR_FIRST   = 27'(X_START + 27'(ITER_ID) * DX);
  localparam logic [26:0] CR_STEP    = 27'(27'(N_ITER) * DX);
  localparam bit          HAS_PIXELS = (ITER_ID < X_RES);

  state_t      state;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] row_base;
  logic [31:0] x_next;
  logic [2:0]  bucket;
  logic [7:0]  colour;
  logic        unused_flag_bits;

  function automatic logic [7:0] palette(input logic [2:0] b);
    case (b)
      3'd0:    palette = 8'h03;
      3'd1:    palette = 8'h07;
      3'd2:    palette = 8'h1F;
      3'd3:    palette = 8'h1C;
      3'd4:    palette = 8'h3C;
      3'd5:    palette = 8'hFC;
      3'd6:    palette = 8'hE0;
      default: palette = 8'hE3;
    endcase
  endfunction

  // bucket = min(7, floor(log2 core_N)); core_N of 0 falls into bucket 0.
  always_comb begin
    // NOTE: default first so every path assigns bucket; otherwise a latch is inferred.
    bucket = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if ((core_N >> i) != 27'd0) bucket = 3'(i);
    end
    colour = (core_N >= max_iterations) ? 8'h00 : palette(bucket);
  end

  assign x_next           = x + X_STEP;
  assign unused_flag_bits = ^core_flag[26:1];

  // start has priority in every state: it rewinds to pixel (ITER_ID, 0) and drops any pending pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      state       <= IDLE;
      x           <= X_FIRST;
      y           <= '0;
      row_base    <= '0;
      cr          <= CR_FIRST;
      ci          <= Y_START;
      core_reset  <= 1'b1;
      select      <= 1'b0;
      done        <= 1'b0;
      vga_addr    <= '0;
      vga_pxl_clr <= '0;
    end else if (start) begin
      x          <= X_FIRST;
      y          <= '0;
      row_base   <= '0;
      cr         <= CR_FIRST;
      ci         <= Y_START;
      core_reset <= 1'b1;
      select     <= 1'b0;
      if (HAS_PIXELS) begin
        done  <= 1'b0;
        state <= LOAD;
      end else begin
        done  <= 1'b1;
        state <= DONE;
      end
    end else begin
      case (state)
        IDLE: begin
          core_reset <= 1'b1;
          select     <= 1'b0;
        end
        LOAD: begin
          core_reset <= 1'b0;
          state      <= RUN;
        end
        RUN: begin
          if (core_flag[0]) begin
            vga_addr    <= row_base + x;
            vga_pxl_clr <= {24'd0, colour};
            select      <= 1'b1;
            core_reset  <= 1'b1;
            state       <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (comp_flag) begin
            select <= 1'b0;
            state  <= ADVANCE;
          end
        end
        ADVANCE: begin
          if (x_next >= X_LIMIT) begin
            x        <= X_FIRST;
            cr       <= CR_FIRST;
            ci       <= ci - DY;
            y        <= y + 32'd1;
            row_base <= row_base + X_LIMIT;
            if (y == Y_LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= LOAD;
            end
          end else begin
            x     <= x_next;
            cr    <= cr + CR_STEP;
            state <= LOAD;
          end
        end
        DONE: begin
          core_reset <= 1'b1;
          select     <= 1'b0;
          done       <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_iter_ctrl.sv
// Bench for mandel_iter_ctrl: a scripted core on a 4x2 screen (ITER_ID=1, N_ITER=2), real-arithmetic
// cores for the in-set / escape colour cases, and an instance that owns no pixels.
module tb_mandel_iter_ctrl;

  localparam int          XR       = 4;
  localparam int          YR       = 2;
  localparam logic [26:0] DX       = 27'd39322;
  localparam logic [26:0] DY       = 27'd34953;
  localparam logic [26:0] A_XS     = 27'h7000000;
  localparam logic [26:0] A_YS     = 27'h0800000;
  localparam logic [26:0] C_XS     = 27'h0800000;
  localparam logic [26:0] REAL_MAX = 27'd20;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // ---------------- instance a: scripted core ----------------
  logic [26:0] a_max = 27'd300;
  logic [26:0] a_core_N, a_core_flag, a_cr, a_ci;
  logic        a_comp = 1'b0;
  logic        a_core_reset, a_select, a_done;
  logic [31:0] a_addr, a_clr;

  mandel_iter_ctrl #(.ITER_ID(1), .N_ITER(2), .X_RES(XR), .Y_RES(YR),
                     .X_START(A_XS), .Y_START(A_YS), .DX(DX), .DY(DY)) dut_a (
    .clk(clk), .reset(reset), .start(start), .max_iterations(a_max),
    .core_N(a_core_N), .core_flag(a_core_flag), .comp_flag(a_comp),
    .core_reset(a_core_reset), .cr(a_cr), .ci(a_ci), .vga_addr(a_addr),
    .vga_pxl_clr(a_clr), .select(a_select), .done(a_done));

  int          a_lat = 1;
  int          a_cnt = 0;
  logic        a_flag = 1'b0;
  logic [26:0] a_nval = '0;
  logic [25:0] a_junk = '0;

  // Count values favour the palette and in-set boundaries.
  function automatic logic [26:0] pick_n(input logic [26:0] mx);
    case ($urandom_range(0, 11))
      0:       return 27'd0;
      1:       return 27'd1;
      2:       return 27'd2;
      3:       return 27'd3;
      4:       return 27'd127;
      5:       return 27'd128;
      6:       return mx - 27'd1;
      7:       return mx;
      8:       return mx + 27'd1;
      default: return 27'($urandom_range(0, 32'(mx) + 32'd40));
    endcase
  endfunction

  always @(posedge clk) begin
    a_junk <= 26'($urandom);
    if (a_core_reset) begin
      a_cnt  <= 0;
      a_flag <= 1'b0;
      a_lat  <= int'($urandom_range(1, 5));
    end else if (!a_flag) begin
      a_cnt <= a_cnt + 1;
      if (a_cnt + 1 >= a_lat) begin
        a_flag <= 1'b1;
        a_nval <= pick_n(a_max);
      end
    end
  end

  assign a_core_N    = a_nval;
  assign a_core_flag = {a_junk, a_flag};

  // ---------------- instances b/c: real-arithmetic cores ----------------
  function automatic int escape_count(input logic [26:0] c_re, input logic [26:0] c_im, input int max_it);
    real cre, cim, zr, zi, t;
    int  n;
    cre = $itor($signed(c_re)) / 8388608.0;
    cim = $itor($signed(c_im)) / 8388608.0;
    zr  = 0.0;
    zi  = 0.0;
    n   = 0;
    while (n < max_it && (zr * zr + zi * zi) <= 4.0) begin
      t  = zr * zr - zi * zi + cre;
      zi = 2.0 * zr * zi + cim;
      zr = t;
      n++;
    end
    return n;
  endfunction

  logic [26:0] b_core_N, b_core_flag, b_cr, b_ci, c_core_N, c_core_flag, c_cr, c_ci;
  logic        b_core_reset, b_select, b_done, c_core_reset, c_select, c_done;
  logic [31:0] b_addr, b_clr, c_addr, c_clr;
  int          b_n = 0, b_cnt = 0, c_n = 0, c_cnt = 0;
  logic        b_flag = 1'b0, c_flag = 1'b0;

  mandel_iter_ctrl #(.ITER_ID(0), .N_ITER(2), .X_RES(XR), .Y_RES(YR),
                     .X_START(27'd0), .Y_START(27'd0), .DX(DX), .DY(DY)) dut_b (
    .clk(clk), .reset(reset), .start(start), .max_iterations(REAL_MAX),
    .core_N(b_core_N), .core_flag(b_core_flag), .comp_flag(b_select),
    .core_reset(b_core_reset), .cr(b_cr), .ci(b_ci), .vga_addr(b_addr),
    .vga_pxl_clr(b_clr), .select(b_select), .done(b_done));

  mandel_iter_ctrl #(.ITER_ID(0), .N_ITER(2), .X_RES(XR), .Y_RES(YR),
                     .X_START(C_XS), .Y_START(27'd0), .DX(DX), .DY(DY)) dut_c (
    .clk(clk), .reset(reset), .start(start), .max_iterations(REAL_MAX),
    .core_N(c_core_N), .core_flag(c_core_flag), .comp_flag(c_select),
    .core_reset(c_core_reset), .cr(c_cr), .ci(c_ci), .vga_addr(c_addr),
    .vga_pxl_clr(c_clr), .select(c_select), .done(c_done));

  always @(posedge clk) begin
    if (b_core_reset) begin
      b_n    <= escape_count(b_cr, b_ci, int'(REAL_MAX));
      b_cnt  <= 0;
      b_flag <= 1'b0;
    end else if (!b_flag) begin
      b_cnt <= b_cnt + 1;
      if (b_cnt + 1 >= ((b_n < 1) ? 1 : b_n)) b_flag <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (c_core_reset) begin
      c_n    <= escape_count(c_cr, c_ci, int'(REAL_MAX));
      c_cnt  <= 0;
      c_flag <= 1'b0;
    end else if (!c_flag) begin
      c_cnt <= c_cnt + 1;
      if (c_cnt + 1 >= ((c_n < 1) ? 1 : c_n)) c_flag <= 1'b1;
    end
  end

  assign b_core_N    = 27'(b_n);
  assign b_core_flag = {26'd0, b_flag};
  assign c_core_N    = 27'(c_n);
  assign c_core_flag = {26'd0, c_flag};

  // ---------------- instance d: owns no columns ----------------
  logic [26:0] d_cr, d_ci;
  logic        d_core_reset, d_select, d_done;
  logic [31:0] d_addr, d_clr;

  mandel_iter_ctrl #(.ITER_ID(5), .N_ITER(6), .X_RES(XR), .Y_RES(YR)) dut_d (
    .clk(clk), .reset(reset), .start(start), .max_iterations(REAL_MAX),
    .core_N(27'd0), .core_flag(27'd0), .comp_flag(1'b0),
    .core_reset(d_core_reset), .cr(d_cr), .ci(d_ci), .vga_addr(d_addr),
    .vga_pxl_clr(d_clr), .select(d_select), .done(d_done));

  // ---------------- reference model for instance a ----------------
  typedef struct {
    int addr;
    int x;
    int y;
  } pix_t;

  pix_t exp_q[$];

  function automatic void build_ref();
    pix_t p;
    exp_q.delete();
    for (int yy = 0; yy < YR; yy++) begin
      for (int xx = 1; xx < XR; xx += 2) begin
        p.addr = yy * XR + xx;
        p.x    = xx;
        p.y    = yy;
        exp_q.push_back(p);
      end
    end
  endfunction

  function automatic logic [26:0] cr_ref(input int xx);
    return A_XS + 27'(xx) * DX;
  endfunction

  function automatic logic [26:0] ci_ref(input int yy);
    return A_YS - 27'(yy) * DY;
  endfunction

  function automatic logic [7:0] colour_of(input logic [26:0] n, input logic [26:0] mx);
    logic [7:0] lut [8];
    int         b;
    lut = '{8'h03, 8'h07, 8'h1F, 8'h1C, 8'h3C, 8'hFC, 8'hE0, 8'hE3};
    if (n >= mx) return 8'h00;
    b = 0;
    while (b < 7 && (64'd1 << (b + 1)) <= 64'(n)) b++;
    return lut[b];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for instance a to present a pixel; comp_flag is toggled randomly meanwhile.
  task automatic wait_select(output logic ok);
    ok = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (a_select) begin
        ok = 1'b1;
        break;
      end
      a_comp = 1'($urandom_range(0, 1));
    end
    a_comp = 1'b0;
  endtask

  // Serves pixels [first, first+count) of the reference order; delay < 0 picks 0..3 cycles.
  task automatic serve(input int first, input int count, input int delay);
    logic        ok;
    int          d;
    logic [31:0] addr0, clr0, exp_clr;
    pix_t        p;
    for (int i = first; i < first + count; i++) begin
      p = exp_q[i];
      wait_select(ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL select_timeout: pixel %0d never presented", i);
        return;
      end
      exp_clr = {24'd0, colour_of(a_nval, a_max)};
      n_checks++;
      if (a_addr !== 32'(p.addr)) begin
        n_fail++;
        $display("FAIL vga_addr pixel %0d: got %0d expected %0d", i, a_addr, p.addr);
      end
      n_checks++;
      if (a_clr !== exp_clr) begin
        n_fail++;
        $display("FAIL colour pixel %0d (N=%0d max=%0d): got %h expected %h", i, a_nval, a_max, a_clr, exp_clr);
      end
      n_checks++;
      if (a_cr !== cr_ref(p.x)) begin
        n_fail++;
        $display("FAIL cr pixel %0d: got %h expected %h", i, a_cr, cr_ref(p.x));
      end
      n_checks++;
      if (a_ci !== ci_ref(p.y)) begin
        n_fail++;
        $display("FAIL ci pixel %0d: got %h expected %h", i, a_ci, ci_ref(p.y));
      end
      addr0 = a_addr;
      clr0  = a_clr;
      d = (delay < 0) ? int'($urandom_range(0, 3)) : delay;
      for (int k = 0; k < d; k++) begin
        @(negedge clk);
        n_checks++;
        if (a_select !== 1'b1 || a_addr !== addr0 || a_clr !== clr0) begin
          n_fail++;
          $display("FAIL hold pixel %0d cycle %0d: select=%b addr=%0d clr=%h expected 1/%0d/%h",
                   i, k, a_select, a_addr, a_clr, addr0, clr0);
        end
      end
      a_comp = 1'b1;
      @(negedge clk);
      a_comp = 1'b0;
      n_checks++;
      if (a_select !== 1'b0) begin
        n_fail++;
        $display("FAIL select_release pixel %0d: got %b expected 0", i, a_select);
      end
    end
  endtask

  task automatic expect_done();
    logic seen, dup, bad_hold;
    seen = 1'b0;
    dup  = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (a_select) dup = 1'b1;
      if (a_done) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen || dup) begin
      n_fail++;
      $display("FAIL done_after_frame: done seen=%b extra select=%b expected 1/0", seen, dup);
    end
    bad_hold = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (a_done !== 1'b1 || a_select !== 1'b0 || a_core_reset !== 1'b1) bad_hold = 1'b1;
    end
    n_checks++;
    if (bad_hold) begin
      n_fail++;
      $display("FAIL done_hold: done=%b select=%b core_reset=%b expected 1/0/1", a_done, a_select, a_core_reset);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic bad;
    #12;
    n_checks++;
    if (a_select !== 1'b0 || a_done !== 1'b0 || a_core_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctrl: select=%b done=%b core_reset=%b expected 0/0/1", a_select, a_done, a_core_reset);
    end
    n_checks++;
    if (a_addr !== 32'd0 || a_clr !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_pixel: addr=%0d clr=%h expected 0/0", a_addr, a_clr);
    end
    n_checks++;
    if (a_cr !== cr_ref(1) || a_ci !== ci_ref(0)) begin
      n_fail++;
      $display("FAIL reset_c: cr=%h ci=%h expected %h/%h", a_cr, a_ci, cr_ref(1), ci_ref(0));
    end
    n_checks++;
    if (d_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_empty_done: got %b expected 0", d_done);
    end
    @(negedge clk);
    reset = 1'b1;
    bad = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (a_select !== 1'b0 || a_core_reset !== 1'b1) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL idle_without_start: select=%b core_reset=%b expected 0/1", a_select, a_core_reset);
    end
  endtask

  task automatic test_async_reset_mid_run();
    logic ok;
    pulse_start();
    serve(0, 1, 0);
    ok = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      if (!a_core_reset) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL run_timeout: core_reset never released");
    end
    n_checks++;
    if (a_addr !== 32'd1) begin
      n_fail++;
      $display("FAIL pre_reset_addr: got %0d expected 1", a_addr);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (a_select !== 1'b0 || a_done !== 1'b0 || a_core_reset !== 1'b1 || a_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: select=%b done=%b core_reset=%b addr=%0d expected 0/0/1/0",
               a_select, a_done, a_core_reset, a_addr);
    end
    n_checks++;
    if (a_cr !== cr_ref(1) || a_ci !== ci_ref(0) || a_clr !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset_c: cr=%h ci=%h clr=%h expected %h/%h/0", a_cr, a_ci, a_clr, cr_ref(1), ci_ref(0));
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_frame_instant();
    pulse_start();
    n_checks++;
    if (d_done !== 1'b1 || d_select !== 1'b0 || d_core_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_instance: done=%b select=%b core_reset=%b expected 1/0/1", d_done, d_select, d_core_reset);
    end
    serve(0, 4, 0);
    expect_done();
  endtask

  task automatic test_restart_random();
    for (int r = 0; r < 3; r++) begin
      a_max = 27'($urandom_range(40, 300));
      pulse_start();
      serve(0, 4, -1);
      expect_done();
    end
  endtask

  task automatic test_ack_delay();
    a_max = 27'd300;
    pulse_start();
    serve(0, 1, 10);
    serve(1, 3, 0);
    expect_done();
  endtask

  task automatic test_start_during_wait_ack();
    logic ok;
    pulse_start();
    serve(0, 2, -1);
    wait_select(ok);
    n_checks++;
    if (!ok || a_addr !== 32'(exp_q[2].addr)) begin
      n_fail++;
      $display("FAIL third_pixel: seen=%b addr=%0d expected 1/%0d", ok, a_addr, exp_q[2].addr);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (a_select !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_select_drop: got %b expected 0", a_select);
    end
    serve(0, 4, -1);
    expect_done();
  endtask

  task automatic test_real_core();
    logic        b_seen, c_seen;
    logic [31:0] b_pix, c_pix, b_at;
    logic [26:0] c_cr_at;
    logic [31:0] exp_b, exp_c;
    b_seen = 1'b0;
    c_seen = 1'b0;
    b_pix = '0; c_pix = '0; b_at = '0; c_cr_at = '0;
    exp_b = {24'd0, colour_of(27'(escape_count(27'd0, 27'd0, int'(REAL_MAX))), REAL_MAX)};
    exp_c = {24'd0, colour_of(27'(escape_count(C_XS, 27'd0, int'(REAL_MAX))), REAL_MAX)};
    pulse_start();
    for (int cyc = 0; cyc < 300 && !(b_seen && c_seen); cyc++) begin
      @(negedge clk);
      if (b_select && !b_seen) begin
        b_seen = 1'b1;
        b_pix  = b_clr;
        b_at   = b_addr;
      end
      if (c_select && !c_seen) begin
        c_seen  = 1'b1;
        c_pix   = c_clr;
        c_cr_at = c_cr;
      end
    end
    n_checks++;
    if (!b_seen || !c_seen) begin
      n_fail++;
      $display("FAIL real_core_timeout: b seen=%b c seen=%b expected 1/1", b_seen, c_seen);
    end
    n_checks++;
    if (b_pix !== 32'd0 || b_pix !== exp_b || b_at !== 32'd0) begin
      n_fail++;
      $display("FAIL in_set_colour: clr=%h addr=%0d expected %h/0", b_pix, b_at, exp_b);
    end
    n_checks++;
    if (c_pix === 32'd0 || c_pix !== exp_c || c_cr_at !== C_XS) begin
      n_fail++;
      $display("FAIL escape_colour: clr=%h cr=%h expected %h (nonzero)/%h", c_pix, c_cr_at, exp_c, C_XS);
    end
  endtask

  initial begin
    build_ref();
    test_reset();
    test_async_reset_mid_run();
    test_frame_instant();
    test_restart_random();
    test_ack_delay();
    test_start_during_wait_ack();
    test_real_core();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
